bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter for the board display path.
//  Sits between the ssdSel selection mux and the four-digit seven-segment driver.
//  Each selected 13-bit debug value (PC, ALU out, regfile data, ...) is shown in decimal, not binary.
//  Converts one bit per clock; holds the last result stable for the display driver.
// PARAMETERS
//  BIN_W   13  width of the binary input
//  DIGITS  4   number of BCD digits produced (each digit is 4 bits)
// PORTS
//  clk       in   1          system clock; all state on the rising edge
//  rst       in   1          synchronous, active-high reset
//  start     in   1          request a conversion of bin_in; sampled on the rising edge
//  bin_in    in   BIN_W      unsigned binary value, sampled only when start is accepted
//  busy      out  1          high while a conversion is in progress (state SHIFT)
//  done      out  1          one-cycle pulse: bcd_out/overflow just updated
//  bcd_out   out  4*DIGITS   packed BCD, digit 0 in [3:0]; registered, holds until next done
//  overflow  out  1          last result exceeded 10^DIGITS-1; bcd_out then holds low digits
// BEHAVIOUR
//  Clocking/reset:
//   - one clock, clk; rst is synchronous active-high and has priority over everything.
//   - Reset values: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, shift counter=0.
//   - rst asserted mid-conversion aborts it; no done pulse follows; bcd_out reads 0.
//  FSM states: IDLE, SHIFT, DONE.
//   - IDLE:  start=1 -> load bin_in into the binary shift reg, clear the BCD work reg.
//            Clear the overflow work bit, count=0, go to SHIFT. start=0 -> stay.
//   - SHIFT: each cycle, every work digit >=5 gets +3 (all digits in parallel).
//            Then {bcd_work, bin_shift} shifts left 1; count increments.
//            A 1 shifted out of the top digit's MSB sets the overflow work bit (sticky).
//            On the edge performing shift number BIN_W: bcd_out<=final work value,
//            overflow<=work bit, go to DONE.
//   - DONE:  done=1 for exactly this cycle; busy=0.
//            start=1 -> accepted exactly as in IDLE (back-to-back), go to SHIFT.
//            Otherwise go to IDLE.
//  Handshake and latency:
//   - start is ignored while busy=1 (no queueing, no restart, bin_in not re-sampled).
//   - Start accepted at edge k -> busy=1 in cycles k+1..k+BIN_W.
//   - done=1 in cycle k+BIN_W+1.
//   - bcd_out is valid from the same cycle done=1 and never changes except on a done-producing edge or rst.
//  Arithmetic rules:
//   - Add-3 is applied before the shift, using the 4-bit digit value; no carry between digits.
//   - Input is unsigned; there is no sign handling.
//   - With defaults, the max input 8191 fits, so overflow stays 0.
//   - Counter width is clog2(BIN_W+1); it never wraps within a conversion.
//  Outputs are driven from registers only; no combinational path from inputs to outputs.
// TESTING
//  1 rst, start with bin_in=0 -> busy 13 cycles; done pulse at k+14; bcd_out=16'h0000; overflow=0.
//  2 bin_in=1234; then 8191; then 4095 -> bcd_out=16'h1234, 16'h8191, 16'h4095; latency exactly 14 each.
//  3 start with bin_in=57, then start=1 with bin_in=999 in cycle k+5 -> ignored; result 16'h0057; one done.
//  4 start 8191; rst=1 in cycle k+6 -> next cycle busy=0, done=0, bcd_out=0; no done pulse later.
//  5 start held high continuously, bin_in=42 then 43 -> conversions chain through DONE->SHIFT.
//     Done pulses are 14 cycles apart; results 16'h0042 then 16'h0043.
//  6 BIN_W=14, DIGITS=4, bin_in=12345 -> overflow=1, bcd_out=16'h2345.
//     Then bin_in=9999 -> overflow=0, bcd_out=16'h9999.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// last result held on bcd_out for the seven-segment display driver.
module bin2bcd_seq #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               last;
  logic               busy_q, done_q, ovf_out_q;
  logic [BCD_W-1:0]   bcd_out_q;

  // Each digit >= 5 gets +3 independently; no carry crosses digit boundaries.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] w);
    logic [BCD_W-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    adj   = add3_digits(bcd_q);
    bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_d = bin_q << 1;
    ovf_d = ovf_q | adj[BCD_W-1];
    last  = (cnt_q == CNT_W'(BIN_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      ovf_out_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_q   <= bin_in;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            bcd_out_q <= bcd_d;
            ovf_out_q <= ovf_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = ovf_out_q;

endmodule
